// File: rtl/seq_gen_pkg.sv
// Shared types for the parametrised sequence generator: recurrence modes,
// controller states and datapath control encodings.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    FIB   = 2'b00,
    ARITH = 2'b01,
    SHIFT = 2'b10,
    SUB   = 2'b11
  } seq_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  typedef enum logic [1:0] {
    AS_HOLD = 2'b00,
    AS_ADD  = 2'b01,
    AS_SUB  = 2'b10
  } as_ctl_t;

  typedef enum logic {
    SH_NONE = 1'b0,
    SH_LEFT = 1'b1
  } shift_ctl_t;

endpackage

// File: rtl/seq_gen_param_if.sv
// Request/term bus of the sequence generator; master drives requests and
// stall, slave (the generator) returns terms and status.
interface seq_gen_param_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) ();
  import seq_gen_pkg::*;

  logic             start;
  seq_mode_t        mode;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [CNT_W-1:0] n_terms;
  logic             stall;
  logic [WIDTH-1:0] seq_out;
  logic             valid;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, mode, seed0, seed1, n_terms, stall,
    input  seq_out, valid, busy, done, ovf
  );

  modport slave (
    input  start, mode, seed0, seed1, n_terms, stall,
    output seq_out, valid, busy, done, ovf
  );
endinterface

// File: rtl/seq_gen_param_dp.sv
// Datapath: R0/R1 registers, adder/subtractor with carry/borrow and a
// left shifter; reports the wrap event of the update being applied.
module seq_gen_param_dp
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  as_ctl_t          as_ctl,
  input  shift_ctl_t       shift_ctl,
  input  logic             r0_ld,
  input  logic             r1_ld,
  input  logic             r1_src,
  output logic [WIDTH-1:0] r0,
  output logic             ovf_evt
);

  logic [WIDTH-1:0] r0_r;
  logic [WIDTH-1:0] r1_r;
  logic             r1_wrap_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] alu_s;
  logic             alu_c_s;
  logic [WIDTH-1:0] r0_nxt_s;

  assign sum_s  = {1'b0, r0_r} + {1'b0, r1_r};
  assign diff_s = {1'b0, r0_r} - {1'b0, r1_r};
  assign r0     = r0_r;

  // Adder/subtractor result and its carry or borrow.
  always_comb begin
    alu_s   = r0_r;
    alu_c_s = 1'b0;
    case (as_ctl)
      AS_ADD: begin
        alu_s   = sum_s[WIDTH-1:0];
        alu_c_s = sum_s[WIDTH];
      end
      AS_SUB: begin
        alu_s   = diff_s[WIDTH-1:0];
        alu_c_s = diff_s[WIDTH];
      end
      default: begin
        alu_s   = r0_r;
        alu_c_s = 1'b0;
      end
    endcase
  end

  // R0 source select. In the chained (Fibonacci) form the sum lands in R1
  // first, so the wrap is reported when that value moves into R0.
  always_comb begin
    r0_nxt_s = r0_r;
    ovf_evt  = 1'b0;
    if (shift_ctl == SH_LEFT) begin
      r0_nxt_s = {r0_r[WIDTH-2:0], 1'b0};
      ovf_evt  = r0_r[WIDTH-1];
    end else if (r1_src) begin
      r0_nxt_s = r1_r;
      ovf_evt  = r1_wrap_r;
    end else begin
      r0_nxt_s = alu_s;
      ovf_evt  = alu_c_s;
    end
  end

  // Operand registers plus the pending-wrap marker for R1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_r      <= {WIDTH{1'b0}};
      r1_r      <= {WIDTH{1'b0}};
      r1_wrap_r <= 1'b0;
    end else if (load_seed) begin
      r0_r      <= seed0;
      r1_r      <= seed1;
      r1_wrap_r <= 1'b0;
    end else begin
      if (r0_ld) begin
        r0_r <= r0_nxt_s;
      end
      if (r1_ld) begin
        r1_r      <= alu_s;
        r1_wrap_r <= alu_c_s;
      end
    end
  end

endmodule

// File: rtl/seq_gen_param.sv
// Top of the sequence generator: controller FSM, term counter and sticky
// overflow flag around the R0/R1 datapath.
module seq_gen_param
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  seq_gen_param_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  seq_state_t       state_r, state_nxt_s;
  seq_mode_t        mode_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             advance_s;
  logic             load_seed_s;
  as_ctl_t          as_ctl_s;
  shift_ctl_t       shift_ctl_s;
  logic             r0_ld_s;
  logic             r1_ld_s;
  logic             r1_src_s;
  logic [WIDTH-1:0] r0_s;
  logic             ovf_evt_s;

  seq_gen_param_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load_seed (load_seed_s),
    .seed0     (bus.seed0),
    .seed1     (bus.seed1),
    .as_ctl    (as_ctl_s),
    .shift_ctl (shift_ctl_s),
    .r0_ld     (r0_ld_s),
    .r1_ld     (r1_ld_s),
    .r1_src    (r1_src_s),
    .r0        (r0_s),
    .ovf_evt   (ovf_evt_s)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt_s = state_r;
    load_seed_s = 1'b0;
    advance_s   = 1'b0;
    as_ctl_s    = AS_HOLD;
    shift_ctl_s = SH_NONE;
    r0_ld_s     = 1'b0;
    r1_ld_s     = 1'b0;
    r1_src_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_seed_s = 1'b1;
          state_nxt_s = (bus.n_terms == CNT_ZERO) ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          advance_s = 1'b1;
          r0_ld_s   = 1'b1;
          case (mode_r)
            FIB: begin
              as_ctl_s = AS_ADD;
              r1_ld_s  = 1'b1;
              r1_src_s = 1'b1;
            end
            ARITH:   as_ctl_s    = AS_ADD;
            SHIFT:   shift_ctl_s = SH_LEFT;
            SUB:     as_ctl_s    = AS_SUB;
            default: as_ctl_s    = AS_HOLD;
          endcase
          state_nxt_s = (cnt_r == CNT_ONE) ? DONE : RUN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Controller state, latched mode, term counter and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      mode_r  <= FIB;
      cnt_r   <= CNT_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (load_seed_s) begin
        mode_r <= bus.mode;
        cnt_r  <= bus.n_terms;
        ovf_r  <= 1'b0;
      end else if (advance_s) begin
        cnt_r <= cnt_r - CNT_ONE;
        ovf_r <= ovf_r | ovf_evt_s;
      end
    end
  end

  assign bus.seq_out = r0_s;
  assign bus.valid   = (state_r == RUN);
  assign bus.busy    = (state_r != IDLE);
  assign bus.done    = (state_r == DONE);
  assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_seq_gen_param.sv
// Directed bench for seq_gen_param: one task per scenario, hand-computed
// expected terms, flags and cycle counts.
module tb_seq_gen_param;
  import seq_gen_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  seq_gen_param_if #(.WIDTH(16), .CNT_W(8)) bus ();

  seq_gen_param #(.WIDTH(16), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns sampled just after acceptance.
  task automatic start_seq(input seq_mode_t m, input logic [15:0] s0,
                           input logic [15:0] s1, input logic [7:0] n);
    bus.mode    = m;
    bus.seed0   = s0;
    bus.seed1   = s1;
    bus.n_terms = n;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = FIB;
    bus.seed0   = 16'd0;
    bus.seed1   = 16'd0;
    bus.n_terms = 8'd0;
    bus.stall   = 1'b0;
    #12;
    checks++;
    if ({bus.seq_out, bus.valid, bus.busy, bus.done, bus.ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=00000",
               {bus.seq_out, bus.valid, bus.busy, bus.done, bus.ovf});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    start_seq(ARITH, 16'd7, 16'd2, 8'd10);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.seq_out, bus.valid, bus.busy, bus.done, bus.ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_run got=%h want=00000",
               {bus.seq_out, bus.valid, bus.busy, bus.done, bus.ovf});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_fib();
    logic [15:0] exp_t [10] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3,
                                16'd5, 16'd8, 16'd13, 16'd21, 16'd34};
    start_seq(FIB, 16'd0, 16'd1, 8'd10);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.seq_out !== exp_t[i]) begin
        errors++;
        $display("FAIL fib_term%0d got=%0d valid=%b want=%0d valid=1",
                 i, bus.seq_out, bus.valid, exp_t[i]);
      end
      step();
    end
    checks++;
    if ({bus.done, bus.valid, bus.busy, bus.ovf} !== 4'b1010) begin
      errors++;
      $display("FAIL fib_done done/valid/busy/ovf=%b want=1010",
               {bus.done, bus.valid, bus.busy, bus.ovf});
    end
    step();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL fib_idle done/busy=%b want=00", {bus.done, bus.busy});
    end
  endtask

  task automatic test_fib_wrap();
    start_seq(FIB, 16'd0, 16'd1, 8'd26);
    for (int i = 1; i <= 26; i++) begin
      if (i == 25) begin
        checks++;
        if (bus.seq_out !== 16'd46368 || bus.ovf !== 1'b0) begin
          errors++;
          $display("FAIL fibw_term25 got=%0d ovf=%b want=46368 ovf=0",
                   bus.seq_out, bus.ovf);
        end
      end
      if (i == 26) begin
        checks++;
        if (bus.seq_out !== 16'd9489 || bus.ovf !== 1'b1) begin
          errors++;
          $display("FAIL fibw_term26 got=%0d ovf=%b want=9489 ovf=1",
                   bus.seq_out, bus.ovf);
        end
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL fibw_done done=%b ovf=%b want done=1 ovf=1", bus.done, bus.ovf);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL fibw_sticky busy=%b ovf=%b want busy=0 ovf=1", bus.busy, bus.ovf);
    end
  endtask

  task automatic test_arith_stall();
    logic [15:0] exp_t [6] = '{16'd5, 16'd8, 16'd8, 16'd8, 16'd11, 16'd14};
    logic        stl   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int busy_cycles = 0;
    int guard = 0;
    start_seq(ARITH, 16'd5, 16'd3, 8'd4);
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL arith_ovf_cleared ovf=%b want=0", bus.ovf);
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.seq_out !== exp_t[j]) begin
        errors++;
        $display("FAIL arith_term%0d got=%0d valid=%b want=%0d valid=1",
                 j, bus.seq_out, bus.valid, exp_t[j]);
      end
      if (bus.busy) busy_cycles++;
      bus.stall = stl[j];
      step();
    end
    bus.stall = 1'b0;
    while (bus.busy && guard < 10) begin
      busy_cycles++;
      guard++;
      step();
    end
    checks++;
    if (busy_cycles != 7) begin
      errors++;
      $display("FAIL arith_busy_cycles got=%0d want=7", busy_cycles);
    end
  endtask

  task automatic test_shift_sub();
    logic [15:0] sh_t [3] = '{16'h6000, 16'hC000, 16'h8000};
    logic        sh_o [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] sb_t [4] = '{16'd10, 16'd6, 16'd2, 16'd65534};
    logic        sb_o [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    start_seq(SHIFT, 16'h6000, 16'd0, 8'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.seq_out !== sh_t[i] || bus.ovf !== sh_o[i]) begin
        errors++;
        $display("FAIL shift_term%0d got=%h ovf=%b want=%h ovf=%b",
                 i, bus.seq_out, bus.ovf, sh_t[i], sh_o[i]);
      end
      step();
    end
    step();
    start_seq(SUB, 16'd10, 16'd4, 8'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.seq_out !== sb_t[i] || bus.ovf !== sb_o[i]) begin
        errors++;
        $display("FAIL sub_term%0d got=%0d ovf=%b want=%0d ovf=%b",
                 i, bus.seq_out, bus.ovf, sb_t[i], sb_o[i]);
      end
      step();
    end
    step();
  endtask

  task automatic test_zero_terms();
    start_seq(FIB, 16'd3, 16'd4, 8'd0);
    checks++;
    if ({bus.valid, bus.done, bus.busy} !== 3'b011) begin
      errors++;
      $display("FAIL zero_done valid/done/busy=%b want=011",
               {bus.valid, bus.done, bus.busy});
    end
    step();
    checks++;
    if ({bus.valid, bus.done, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL zero_idle valid/done/busy=%b want=000",
               {bus.valid, bus.done, bus.busy});
    end
  endtask

  task automatic test_start_ignored();
    int n_valid = 0;
    int guard = 0;
    start_seq(ARITH, 16'd1, 16'd1, 8'd5);
    while (bus.busy && guard < 20) begin
      if (bus.valid) begin
        n_valid++;
        checks++;
        if (bus.seq_out !== 16'(n_valid)) begin
          errors++;
          $display("FAIL ign_term%0d got=%0d want=%0d", n_valid, bus.seq_out, n_valid);
        end
      end
      if (n_valid == 2) begin
        bus.start = 1'b1;
        bus.mode  = SUB;
        bus.seed0 = 16'd100;
      end else begin
        bus.start = 1'b0;
      end
      guard++;
      step();
    end
    bus.start = 1'b0;
    checks++;
    if (n_valid != 5) begin
      errors++;
      $display("FAIL ign_count got=%0d want=5", n_valid);
    end
  endtask

  task automatic test_max_terms();
    int n_valid = 0;
    int guard = 0;
    start_seq(ARITH, 16'd0, 16'd1, 8'd255);
    while (bus.busy && guard < 300) begin
      if (bus.valid) begin
        checks++;
        if (bus.seq_out !== 16'(n_valid)) begin
          errors++;
          $display("FAIL max_term%0d got=%0d want=%0d", n_valid, bus.seq_out, n_valid);
        end
        n_valid++;
      end
      guard++;
      step();
    end
    checks++;
    if (n_valid != 255 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL max_count got=%0d busy=%b want=255 busy=0", n_valid, bus.busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fib();
    test_fib_wrap();
    test_arith_stall();
    test_shift_sub();
    test_zero_terms();
    test_start_ignored();
    test_max_terms();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_gen_param.md
Name: seq_gen_param

Overview:
Parametrised, multi-mode successor to the fixed 16-bit two-register sequence generator.
- Separate datapath (R0/R1, add/sub, shift) and controller FSM, same split as the existing generator.
- Adds: WIDTH generalisation, four selectable recurrences, programmable term count, start/done handshake, consumer stall, sticky overflow flag.
- Used as a stimulus/sequence source feeding downstream datapath blocks.

Parameters:
WIDTH, 16, datapath/register width in bits (>=4)
CNT_W, 8, width of term counter / n_terms

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request new sequence; sampled only in IDLE
mode  in  2  recurrence select (seq_mode_t), latched on accepted start
seed0  in  WIDTH  initial R0
seed1  in  WIDTH  initial R1 (second term / step)
n_terms  in  CNT_W  number of terms to emit; 0 = none
stall  in  1  consumer backpressure; holds current term
seq_out  out  WIDTH  current term (= R0)
valid  out  1  seq_out is a term (state RUN)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after final term
ovf  out  1  sticky overflow/borrow/shift-loss flag for current sequence

Behaviour:
- Reset (async, any state, incl. mid-sequence):
  - state=IDLE; R0=R1=0; cnt=0; mode_q=FIB; ovf=0.
  - seq_out=0, valid=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE with start=1 at edge:
  - R0<=seed0, R1<=seed1, cnt<=n_terms, mode_q<=mode, ovf<=0.
  - Next state RUN, or DONE if n_terms==0.
- IDLE with start=0: hold all registers.
- start outside IDLE: ignored; no effect on the running sequence.
- Latency: first term valid in the cycle after the accepting edge.
- RUN:
  - valid=1, seq_out=R0 (combinational from register).
  - Edge with stall=1: R0/R1/cnt/ovf hold; term repeats.
  - Edge with stall=0: apply recurrence; cnt<=cnt-1; if cnt==1, next state DONE.
- Recurrences (all arithmetic modulo 2^WIDTH; ovf |= event):
  - FIB(00): R0<=R1; R1<=R0+R1; event = carry out of R0+R1.
  - ARITH(01): R0<=R0+R1; R1 holds; event = carry out.
  - SHIFT(10): R0<=R0<<1, zero fill; R1 holds; event = R0[WIDTH-1].
  - SUB(11): R0<=R0-R1; R1 holds; event = borrow (R1>R0).
- Overflow timing: ovf is set by the update that produces the wrapped value, so it is visible in the same cycle as the wrapped term.
- ovf remains set through DONE and IDLE; cleared only by the next accepted start or by reset.
- DONE: done=1, valid=0, busy=1, for exactly one cycle; then IDLE. stall is ignored.
- Total busy cycles = n_terms + 1 + stalled cycles.
- n_terms = 2^CNT_W-1 must emit all terms; the counter must not wrap early.

Decomposition:
- Package seq_gen_pkg:
  - seq_mode_t enum: FIB, ARITH, SHIFT, SUB.
  - seq_state_t enum: IDLE, RUN, DONE.
  - Existing as_ctl_t and shift_ctl_t enums, extended with HOLD encodings where needed.
- Sub-module seq_gen_param_dp (datapath):
  - Contains R0, R1, adder/subtractor with carry/borrow, shifter.
  - Driven by as_ctl, shift_ctl, r0_ld, r1_ld, r1_src, load_seed; returns ovf_evt.
- Top level: controller FSM, term counter, sticky ovf register.

Test Plan:
- Reset mid-RUN: assert reset asynchronously between edges -> outputs 0 immediately, state IDLE; a subsequent start works normally.
- FIB, seeds 0/1, n_terms=10, no stall -> seq_out 0,1,1,2,3,5,8,13,21,34 on 10 consecutive valid cycles; done pulse next cycle; ovf=0.
- FIB, WIDTH=16, seeds 0/1, n_terms=26 -> term 25 = 46368; term 26 = 9489 (75025 mod 65536), ovf=1 from that cycle onward.
- ARITH, seed0=5, seed1=3, n_terms=4, stall high for 2 cycles on the 2nd term -> terms 5,8,8,8,11,14; busy lasts 7 cycles.
- SHIFT, seed0=16'h6000, n_terms=3 -> terms 6000,C000,8000; ovf=1 with 8000. SUB, seeds 10/4, n_terms=4 -> 10,6,2,65534; ovf=1 with 65534.
- n_terms=0 -> no valid cycle, done one cycle after start. start pulsed during RUN -> ignored; term count unchanged.
